id_ex_stage_buf: RTL and testbench
==================================

Name: id_ex_stage_buf

Overview:
- Parametrised ID/EX pipeline stage register that replaces the free-running latch with a valid/ready stage.
- Carries NUM_CH data words (RS, RT, immediate, …), a control bundle and NUM_REG register-index fields from decode to execute.
- A 2-entry skid buffer lets a downstream stall absorb one in-flight instruction without a combinational ready path back into decode.
- Supports synchronous flush (branch/jump squash) and forces control bits to zero on bubbles, so an empty slot can never write the register file or memory.

Parameters:
- DATA_W, 32, width of each data channel.
- NUM_CH, 3, number of data channels (RS data, RT data, sign-extended immediate).
- CTRL_W, 8, width of control bundle (WB, M and EX fields packed by decode).
- REG_W, 5, width of one register index.
- NUM_REG, 4, number of register-index fields (rs, rt-to-mux, rt-to-forwarding, rd).

Ports:
- clk_i  input  1  clock; all state updates on the falling edge (pipeline-register convention).
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  squash everything held in the stage.
- in_valid_i  input  1  decode presents a valid instruction.
- in_ready_o  output  1  stage can accept this cycle; registered.
- in_data_i  input  NUM_CH*DATA_W  data channels; channel k occupies bits [k*DATA_W +: DATA_W].
- in_ctrl_i  input  CTRL_W  control bundle.
- in_reg_i  input  NUM_REG*REG_W  register indices, packed the same way as data.
- out_valid_o  output  1  execute-side payload is valid.
- out_ready_i  input  1  execute can consume this cycle.
- out_data_o  output  NUM_CH*DATA_W  data to execute.
- out_ctrl_o  output  CTRL_W  control to execute; all zero when out_valid_o=0.
- out_reg_o  output  NUM_REG*REG_W  register indices to execute and forwarding.
- occupancy_o  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry M drives the outputs; skid entry S holds overflow. Each entry has a valid bit.
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Consume = out_valid_o & out_ready_i.
  - in_ready_o = !S.valid, taken from the register (no combinational path from out_ready_i).
- Transitions per falling edge, with occupancy shown as M/S:
  - EMPTY (0/0): accept loads M.
  - ONE (1/0):
    - accept & consume: M replaced by the new instruction.
    - accept & !consume: new instruction goes to S; state becomes FULL and in_ready_o drops.
    - consume only: state becomes EMPTY.
  - FULL (1/1): accept is impossible. Consume moves S to M, clears S and raises in_ready_o.
- Ordering is strictly FIFO; no instruction is ever duplicated or lost except by flush or reset.
- Latency: 1 cycle from accept into an empty stage to out_valid_o. Throughput is 1 instruction per cycle while out_ready_i=1.
- Bubble: whenever out_valid_o=0, out_ctrl_o=0. out_data_o and out_reg_o hold their last value (don't-care).
- Flush:
  - Clears M.valid and S.valid on that edge, so occupancy becomes 0.
  - Input offered in the same cycle is dropped.
  - Consume in the same cycle still counts as a completed transfer for downstream.
  - After the flush edge: in_ready_o=1.
- Reset: has priority over flush and over all handshakes.
  - Clears both valid bits and zeroes all stored payloads.
  - Outputs after reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, out_reg_o=0, in_ready_o=1, occupancy_o=0.
  - Reset asserted mid-stall discards both held entries.
- in_valid_i deasserting without acceptance is legal; decode may change its payload freely while not accepted.

Optional Feature:
- Macro: ID_EX_STALL_STAT_EN.
- With the macro defined:
  - Adds output stall_cnt_o (16 bits).
  - Increments on every edge where out_valid_o=1 and out_ready_i=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst_i only; flush does not clear it.
- Without the macro: the port and the counter logic are absent, with no other behavioural change.

Test Plan:
- Reset then idle: assert rst_i for 2 edges → out_valid_o=0, out_ctrl_o=0, out_data_o=0, in_ready_o=1, occupancy_o=0.
- Streaming: out_ready_i=1; send instructions with ctrl 8'h11, 8'h22, 8'h33 and data ch0=32'hA, 32'hB, 32'hC on consecutive edges → same sequence at the outputs 1 edge later, with no gaps.
- Stall/skid: hold out_ready_i=0; send 8'h11 then 8'h22 → occupancy_o=2, in_ready_o=0, outputs hold 8'h11. Raise out_ready_i → 8'h11 then 8'h22 are consumed in order; in_ready_o=1 after the first consume.
- Flush while full: occupancy_o=2, assert flush_i together with in_valid_i (ctrl 8'h44) → next edge out_valid_o=0, out_ctrl_o=0, occupancy_o=0; 8'h44 never appears.
- Reset mid-operation: occupancy_o=1, assert rst_i together with flush_i and in_valid_i → all outputs at reset values; the next accepted instruction appears normally.
- ID_EX_STALL_STAT_EN build: hold out_valid_o=1 and out_ready_i=0 for 5 edges → stall_cnt_o=5. Force the counter near 16'hFFFF → it saturates. Flush → count unchanged.

Source files
------------

// File: rtl/id_ex_stage_buf.sv
// ID/EX valid/ready stage register with 2-entry skid buffer, sync flush, bubble-zeroed control.
// Latency: 1 falling edge from accept into an empty stage; 1 instruction/cycle while out_ready_i=1.
// Backpressure: in_ready_o = !skid.valid, registered; optional stall counter under ID_EX_STALL_STAT_EN.
module id_ex_stage_buf #(
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 3,
    parameter int CTRL_W  = 8,
    parameter int REG_W   = 5,
    parameter int NUM_REG = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [NUM_CH*DATA_W-1:0]  in_data_i,
    input  logic [CTRL_W-1:0]         in_ctrl_i,
    input  logic [NUM_REG*REG_W-1:0]  in_reg_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [NUM_CH*DATA_W-1:0]  out_data_o,
    output logic [CTRL_W-1:0]         out_ctrl_o,
    output logic [NUM_REG*REG_W-1:0]  out_reg_o,
    output logic [1:0]                occupancy_o
`ifdef ID_EX_STALL_STAT_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);

    localparam int DW = NUM_CH * DATA_W;
    localparam int RW = NUM_REG * REG_W;

    logic          m_vld, s_vld;
    logic [DW-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [RW-1:0] m_reg, s_reg;

    logic accept, consume;

    assign accept  = in_valid_i & ~s_vld;
    assign consume = m_vld & out_ready_i;

    // Pipeline-register convention: state moves on the falling edge.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            m_vld  <= 1'b0;
            s_vld  <= 1'b0;
            m_data <= '0;
            s_data <= '0;
            m_ctrl <= '0;
            s_ctrl <= '0;
            m_reg  <= '0;
            s_reg  <= '0;
        end else if (flush_i) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else begin
            case ({m_vld, s_vld})
                2'b00: begin
                    if (accept) begin
                        m_vld  <= 1'b1;
                        m_data <= in_data_i;
                        m_ctrl <= in_ctrl_i;
                        m_reg  <= in_reg_i;
                    end
                end
                2'b10: begin
                    if (accept && consume) begin
                        m_data <= in_data_i;
                        m_ctrl <= in_ctrl_i;
                        m_reg  <= in_reg_i;
                    end else if (accept) begin
                        s_vld  <= 1'b1;
                        s_data <= in_data_i;
                        s_ctrl <= in_ctrl_i;
                        s_reg  <= in_reg_i;
                    end else if (consume) begin
                        m_vld <= 1'b0;
                    end
                end
                2'b11: begin
                    if (consume) begin
                        s_vld  <= 1'b0;
                        m_data <= s_data;
                        m_ctrl <= s_ctrl;
                        m_reg  <= s_reg;
                    end
                end
                default: begin
                    // Skid without main is unreachable; recover to empty.
                    m_vld <= 1'b0;
                    s_vld <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = ~s_vld;
    assign out_valid_o = m_vld;
    assign out_data_o  = m_data;
    assign out_reg_o   = m_reg;
    // A bubble must never carry write enables into execute.
    assign out_ctrl_o  = m_vld ? m_ctrl : '0;
    assign occupancy_o = {1'b0, m_vld} + {1'b0, s_vld};

`ifdef ID_EX_STALL_STAT_EN
    logic [15:0] stall_cnt;

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (m_vld && !out_ready_i && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: directed vector table plus randomized traffic against a FIFO scoreboard.
module tb_id_ex_stage_buf;

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, in_valid_i, out_ready_i;
    logic         in_ready_o, out_valid_o;
    logic [95:0]  in_data_i, out_data_o;
    logic [7:0]   in_ctrl_i, out_ctrl_o;
    logic [19:0]  in_reg_i, out_reg_o;
    logic [1:0]   occupancy_o;
`ifdef ID_EX_STALL_STAT_EN
    logic [15:0]  stall_cnt_o;
    int unsigned  exp_stall = 0;
`endif

    always #5 clk_i = ~clk_i;

    id_ex_stage_buf dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i), .in_reg_i(in_reg_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o), .out_reg_o(out_reg_o),
        .occupancy_o(occupancy_o)
`ifdef ID_EX_STALL_STAT_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [19:0] rg;
    } pay_t;

    typedef struct {
        logic        rst, flush, vld, rdy;
        logic [7:0]  ctrl;
        logic [31:0] d0;
        int          exp_occ;
        logic [7:0]  exp_ctrl;
        logic        chk_zero;
    } vec_t;

    pay_t sb[$];
    vec_t tbl[21];
    int   tests = 0;
    int   fails = 0;

    function automatic pay_t mk(input logic [7:0] c, input logic [31:0] d0);
        pay_t p;
        p.ctrl = c;
        p.data = {d0 ^ 32'h5A5A_0000, ~d0, d0};
        p.rg   = {c[4:0], c[7:3], ~c[4:0], c[4:0] ^ 5'h15};
        return p;
    endfunction

    function automatic vec_t row(input logic r, f, v, y, input logic [7:0] c,
                                 input logic [31:0] d, input int eo,
                                 input logic [7:0] ec, input logic z);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.rdy = y; t.ctrl = c; t.d0 = d;
        t.exp_occ = eo; t.exp_ctrl = ec; t.chk_zero = z;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance one falling edge, update the FIFO model, compare everything.
    task automatic step(input logic r, f, v, y, input pay_t p);
        logic acc, con;
        rst_i = r; flush_i = f; in_valid_i = v; out_ready_i = y;
        in_ctrl_i = p.ctrl; in_data_i = p.data; in_reg_i = p.rg;
        acc = v && (sb.size() < 2);
        con = (sb.size() > 0) && y;
`ifdef ID_EX_STALL_STAT_EN
        if (r) exp_stall = 0;
        else if (sb.size() > 0 && !y && exp_stall < 65535) exp_stall++;
`endif
        @(negedge clk_i);
        #1;
        if (r || f) begin
            sb.delete();
        end else begin
            if (con) void'(sb.pop_front());
            if (acc) sb.push_back(p);
        end
        chk("out_valid", 128'(out_valid_o), 128'(sb.size() > 0));
        chk("in_ready", 128'(in_ready_o), 128'(sb.size() < 2));
        chk("occupancy", 128'(occupancy_o), 128'(sb.size()));
        if (sb.size() > 0) begin
            chk("sb_ctrl", 128'(out_ctrl_o), 128'(sb[0].ctrl));
            chk("sb_data", 128'(out_data_o), 128'(sb[0].data));
            chk("sb_reg", 128'(out_reg_o), 128'(sb[0].rg));
        end else begin
            chk("bubble_ctrl", 128'(out_ctrl_o), 128'(0));
        end
`ifdef ID_EX_STALL_STAT_EN
        chk("stall_cnt", 128'(stall_cnt_o), 128'(exp_stall));
`endif
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_ctrl_i = '0; in_data_i = '0; in_reg_i = '0;

        //              rst flush vld rdy ctrl   d0      occ ctrl  zero
        tbl[0]  = row(1, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 0);
        tbl[1]  = row(1, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 1);
        tbl[2]  = row(0, 0, 1, 1, 8'h11, 32'hA, 1, 8'h11, 0);
        tbl[3]  = row(0, 0, 1, 1, 8'h22, 32'hB, 1, 8'h22, 0);
        tbl[4]  = row(0, 0, 1, 1, 8'h33, 32'hC, 1, 8'h33, 0);
        tbl[5]  = row(0, 0, 0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        tbl[6]  = row(0, 0, 1, 0, 8'h11, 32'h1, 1, 8'h11, 0);
        tbl[7]  = row(0, 0, 1, 0, 8'h22, 32'h2, 2, 8'h11, 0);
        tbl[8]  = row(0, 0, 1, 0, 8'h55, 32'h5, 2, 8'h11, 0);
        tbl[9]  = row(0, 0, 0, 1, 8'h00, 32'h0, 1, 8'h22, 0);
        tbl[10] = row(0, 0, 0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        tbl[11] = row(0, 0, 1, 0, 8'h66, 32'h6, 1, 8'h66, 0);
        tbl[12] = row(0, 0, 1, 0, 8'h77, 32'h7, 2, 8'h66, 0);
        tbl[13] = row(0, 1, 1, 0, 8'h44, 32'h4, 0, 8'h00, 0);
        tbl[14] = row(0, 0, 0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        tbl[15] = row(0, 0, 1, 0, 8'h88, 32'h8, 1, 8'h88, 0);
        tbl[16] = row(1, 1, 1, 1, 8'h99, 32'h9, 0, 8'h00, 1);
        tbl[17] = row(0, 0, 1, 1, 8'hAB, 32'hAB, 1, 8'hAB, 0);
        tbl[18] = row(0, 0, 0, 1, 8'h00, 32'h0, 0, 8'h00, 0);
        tbl[19] = row(0, 0, 1, 0, 8'hCD, 32'hCD, 1, 8'hCD, 0);
        tbl[20] = row(0, 1, 0, 1, 8'h00, 32'h0, 0, 8'h00, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].rdy, mk(tbl[i].ctrl, tbl[i].d0));
            chk($sformatf("row%0d_occ", i), 128'(occupancy_o), 128'(tbl[i].exp_occ));
            chk($sformatf("row%0d_ctrl", i), 128'(out_ctrl_o), 128'(tbl[i].exp_ctrl));
            if (tbl[i].chk_zero) begin
                chk($sformatf("row%0d_rst_data", i), 128'(out_data_o), 128'(0));
                chk($sformatf("row%0d_rst_reg", i), 128'(out_reg_o), 128'(0));
                chk($sformatf("row%0d_rst_rdy", i), 128'(in_ready_o), 128'(1));
            end
        end

        // Random traffic with occasional flushes; the FIFO model checks ordering.
        for (int n = 0; n < 400; n++) begin
            step(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), mk(8'($urandom), $urandom));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, 1'b1, mk(8'h00, 32'h0));

`ifdef ID_EX_STALL_STAT_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(8'h00, 32'h0));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(8'h5E, 32'h5E));
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1'b0, 1'b0, mk(8'h00, 32'h0));
        chk("stall_five", 128'(stall_cnt_o), 128'(5));
        step(1'b0, 1'b1, 1'b0, 1'b1, mk(8'h00, 32'h0));
        chk("stall_after_flush", 128'(stall_cnt_o), 128'(5));
        step(1'b0, 1'b0, 1'b1, 1'b0, mk(8'h6F, 32'h6F));
        for (int n = 0; n < 65540; n++) step(1'b0, 1'b0, 1'b0, 1'b0, mk(8'h00, 32'h0));
        chk("stall_saturate", 128'(stall_cnt_o), 128'(16'hFFFF));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
